// File: rtl/inst_loader.sv
// Boot-time instruction memory loader: assembles a little-endian byte stream into
// 32-bit words, writes them at consecutive word addresses, then verifies a checksum.
//
// state | meaning
// IDLE  | waiting for start; CPU free to run
// HDR0  | accept low byte of word count N
// HDR1  | accept high byte of N; range-check it
// DATA  | accept instruction bytes into lanes 0..3
// WRITE | one-cycle memory write of the assembled word
// CSUM  | accept and compare the checksum byte
// FIN   | one-cycle done pulse
module inst_loader #(
  parameter int DEPTH_WORDS = 128,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_written
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  localparam logic [15:0] DEPTH_N = 16'(DEPTH_WORDS);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] n_words;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic [23:0] word_buf;

  logic        accept;
  logic [15:0] hdr_n;
  logic        n_too_big;
  logic        n_zero;
  logic [15:0] ww_inc;
  logic        last_word;
  logic        csum_ok;

  assign accept    = byte_valid & byte_ready;
  assign hdr_n     = {byte_data, n_words[7:0]};
  assign n_too_big = (hdr_n > DEPTH_N);
  assign n_zero    = (hdr_n == 16'd0);
  assign ww_inc    = words_written + 16'd1;
  assign last_word = (ww_inc == n_words);
  assign csum_ok   = (byte_data == csum);

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_HDR0;
      S_HDR0:  if (accept) state_nxt = S_HDR1;
      S_HDR1: begin
        if (accept) begin
          if (n_too_big)   state_nxt = S_IDLE;
          else if (n_zero) state_nxt = S_CSUM;
          else             state_nxt = S_DATA;
        end
      end
      S_DATA:  if (accept && byte_idx == 2'd3) state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_word ? S_CSUM : S_DATA;
      S_CSUM:  if (accept) state_nxt = csum_ok ? S_FIN : S_IDLE;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_HDR0, S_HDR1, S_DATA, S_CSUM: byte_ready = 1'b1;
      S_WRITE: mem_we = 1'b1;
      S_FIN:   done   = 1'b1;
      default: ;
    endcase
    cpu_hold = busy;
  end

  // Address and data are loaded on the edge entering WRITE and then held, so the
  // memory port shows the last written word whenever mem_we is low.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      n_words       <= '0;
      byte_idx      <= '0;
      csum          <= '0;
      word_buf      <= '0;
      err           <= 1'b0;
      words_written <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err           <= 1'b0;
            words_written <= '0;
            byte_idx      <= '0;
            csum          <= '0;
            n_words       <= '0;
          end
        end
        S_HDR0: if (accept) n_words[7:0] <= byte_data;
        S_HDR1: begin
          if (accept) begin
            n_words[15:8] <= byte_data;
            if (n_too_big) err <= 1'b1;
          end
        end
        S_DATA: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            csum     <= csum + byte_data;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= byte_data;
              2'd1: word_buf[15:8]  <= byte_data;
              2'd2: word_buf[23:16] <= byte_data;
              default: begin
                mem_wdata <= {byte_data, word_buf};
                mem_addr  <= ADDR_W'({words_written, 2'b00});
              end
            endcase
          end
        end
        S_WRITE: words_written <= ww_inc;
        S_CSUM:  if (accept && !csum_ok) err <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: nominal, gapped, empty, oversize, bad-checksum
// and mid-load reset streams, with hand-computed expected writes.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_written;

  int n_checks = 0;
  int n_pass   = 0;
  int n_stall  = 0;
  int n_done   = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  stream[$];

  inst_loader #(.DEPTH_WORDS(128), .ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (done) n_done++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (wa.size() > idx) begin
      check_eq({tag, "_addr"}, wa[idx], a);
      check_eq({tag, "_data"}, wd[idx], d);
    end else begin
      check_eq({tag, "_present"}, 32'(wa.size()), 32'(idx + 1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offers each byte of the stream; returns just after the edge that accepts the last one.
  task automatic send_bytes(input bit gaps);
    int wait_cnt;
    n_stall = 0;
    foreach (stream[i]) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      byte_valid = 1'b1;
      byte_data  = stream[i];
      wait_cnt   = 0;
      while (!byte_ready && wait_cnt < 64) begin
        tick();
        wait_cnt++;
        n_stall++;
      end
      if (wait_cnt >= 64) begin
        check_eq("ready_timeout", 32'(wait_cnt), 32'd0);
        byte_valid = 1'b0;
        return;
      end
      tick();
      byte_valid = 1'b0;
    end
  endtask

  task automatic nominal_load(input string tag, input bit gaps);
    int wbase, dbase;
    wbase = wa.size();
    dbase = n_done;
    do_start();
    check_eq({tag, "_busy_t1"}, 32'(busy), 32'd1);
    check_eq({tag, "_hold_t1"}, 32'(cpu_hold), 32'd1);
    check_eq({tag, "_ready_t1"}, 32'(byte_ready), 32'd1);
    check_eq({tag, "_err_clr"}, 32'(err), 32'd0);
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    send_bytes(gaps);
    if (!gaps) check_eq({tag, "_stalls"}, 32'(n_stall), 32'd2);
    check_eq({tag, "_done_fin"}, 32'(done), 32'd1);
    tick();
    check_eq({tag, "_done_once"}, 32'(done), 32'd0);
    check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_ww"}, 32'(words_written), 32'd2);
    check_eq({tag, "_nwrites"}, 32'(wa.size() - wbase), 32'd2);
    check_write({tag, "_w0"}, wbase, 32'h0, 32'h0000_0013);
    check_write({tag, "_w1"}, wbase + 1, 32'h4, 32'h0010_0093);
    check_eq({tag, "_ndone"}, 32'(n_done - dbase), 32'd1);
    check_eq({tag, "_addr_hold"}, mem_addr, 32'h4);
    check_eq({tag, "_data_hold"}, mem_wdata, 32'h0010_0093);
  endtask

  initial begin
    int wbase, dbase;
    repeat (3) tick();
    check_eq("rst_ready", 32'(byte_ready), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_hold", 32'(cpu_hold), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    check_eq("rst_ww", 32'(words_written), 32'd0);
    rstn = 1'b1;
    tick();

    nominal_load("nom", 1'b0);
    repeat (2) tick();
    nominal_load("gap", 1'b1);
    tick();

    // Empty load, good checksum
    wbase = wa.size(); dbase = n_done;
    do_start();
    stream = '{8'h00, 8'h00, 8'h00};
    send_bytes(1'b0);
    check_eq("n0_done", 32'(done), 32'd1);
    tick();
    check_eq("n0_nwrites", 32'(wa.size() - wbase), 32'd0);
    check_eq("n0_ndone", 32'(n_done - dbase), 32'd1);
    check_eq("n0_err", 32'(err), 32'd0);

    // Empty load, bad checksum
    wbase = wa.size(); dbase = n_done;
    do_start();
    stream = '{8'h00, 8'h00, 8'h01};
    send_bytes(1'b0);
    check_eq("n0bad_err", 32'(err), 32'd1);
    check_eq("n0bad_busy", 32'(busy), 32'd0);
    tick();
    check_eq("n0bad_ndone", 32'(n_done - dbase), 32'd0);

    // Oversize count, then a valid load clears err
    wbase = wa.size(); dbase = n_done;
    do_start();
    stream = '{8'h81, 8'h00};
    send_bytes(1'b0);
    check_eq("big_err", 32'(err), 32'd1);
    check_eq("big_busy", 32'(busy), 32'd0);
    check_eq("big_ready", 32'(byte_ready), 32'd0);
    repeat (2) tick();
    check_eq("big_nwrites", 32'(wa.size() - wbase), 32'd0);
    check_eq("big_ndone", 32'(n_done - dbase), 32'd0);
    nominal_load("after_big", 1'b0);
    tick();

    // Checksum mismatch on one word
    wbase = wa.size(); dbase = n_done;
    do_start();
    stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
    send_bytes(1'b0);
    check_eq("bad_err", 32'(err), 32'd1);
    check_eq("bad_busy", 32'(busy), 32'd0);
    tick();
    check_eq("bad_nwrites", 32'(wa.size() - wbase), 32'd1);
    check_write("bad_w0", wbase, 32'h0, 32'h0000_0013);
    check_eq("bad_ndone", 32'(n_done - dbase), 32'd0);
    check_eq("bad_ww", 32'(words_written), 32'd1);
    rstn = 1'b0;
    tick();
    check_eq("rst_clr_err", 32'(err), 32'd0);
    rstn = 1'b1;
    tick();

    // Reset during the second word
    wbase = wa.size(); dbase = n_done;
    do_start();
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    send_bytes(1'b0);
    check_eq("mid_busy_pre", 32'(busy), 32'd1);
    rstn = 1'b0;
    tick();
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_hold", 32'(cpu_hold), 32'd0);
    check_eq("mid_ready", 32'(byte_ready), 32'd0);
    check_eq("mid_we", 32'(mem_we), 32'd0);
    check_eq("mid_addr", mem_addr, 32'd0);
    check_eq("mid_wdata", mem_wdata, 32'd0);
    check_eq("mid_ww", 32'(words_written), 32'd0);
    repeat (3) tick();
    check_eq("mid_nwrites", 32'(wa.size() - wbase), 32'd1);
    check_eq("mid_ndone", 32'(n_done - dbase), 32'd0);
    rstn = 1'b1;
    tick();
    nominal_load("post_rst", 1'b0);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
